// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift mode encodings
// and the shift-amount width helper.
package pipelined_barrel_shifter_pkg;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready operand and result bus of the pipelined barrel shifter.
// out_carry exists only when SHIFTER_CARRY_EN is defined.
interface pipelined_barrel_shifter_if
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = shamt_width(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
`ifdef SHIFTER_CARRY_EN
    logic               out_carry;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/pipelined_barrel_shifter_shifter_stage.sv
// One pipeline stage: COUNT shift levels (MSB-first, starting at level index
// FIRST) followed by the stage register. Carries a carry bit when SHIFTER_CARRY_EN.
module pipelined_barrel_shifter_shifter_stage
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int FIRST   = 0,
    parameter int COUNT   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               prev_valid,
    input  logic [WIDTH-1:0]   prev_data,
    input  logic [SHAMT_W-1:0] prev_shamt,
    input  logic [1:0]         prev_mode,
    input  logic               prev_sign,
    input  logic               next_adv,
    output logic               valid_r,
    output logic [WIDTH-1:0]   data_r,
    output logic [SHAMT_W-1:0] shamt_r,
    output logic [1:0]         mode_r,
    output logic               sign_r,
`ifdef SHIFTER_CARRY_EN
    input  logic               prev_carry,
    output logic               carry_r,
`endif
    output logic               adv
);

    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             sign,
        input int               n
    );
        logic [WIDTH-1:0] ones;
        ones = {WIDTH{1'b1}};
        case (mode)
            SHIFT_SLL: shift_level = d << n;
            SHIFT_SRL: shift_level = d >> n;
            SHIFT_SRA: shift_level = (d >> n) | (sign ? ~(ones >> n) : {WIDTH{1'b0}});
            SHIFT_ROR: shift_level = (d >> n) | (d << (WIDTH - n));
            default:   shift_level = d;
        endcase
    endfunction

    logic [WIDTH-1:0] lvl_s [COUNT+1];

    assign lvl_s[0] = prev_data;

    for (genvar j = 0; j < COUNT; j++) begin : g_level
        localparam int K = SHAMT_W - 1 - FIRST - j;
        assign lvl_s[j+1] = prev_shamt[K] ? shift_level(lvl_s[j], prev_mode, prev_sign, 1 << K)
                                          : lvl_s[j];
    end

    // A stage moves on when it is empty or its successor is moving on.
    assign adv = ~valid_r | next_adv;

    // Stage register; payload only loads on a valid transfer so held results stay put.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            shamt_r <= {SHAMT_W{1'b0}};
            mode_r  <= 2'b00;
            sign_r  <= 1'b0;
        end else if (adv) begin
            valid_r <= prev_valid;
            if (prev_valid) begin
                data_r  <= lvl_s[COUNT];
                shamt_r <= prev_shamt;
                mode_r  <= prev_mode;
                sign_r  <= prev_sign;
            end
        end
    end

`ifdef SHIFTER_CARRY_EN
    // Carry rides along with its result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            carry_r <= 1'b0;
        end else if (adv && prev_valid) begin
            carry_r <= prev_carry;
        end
    end
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready backpressure.
// Define SHIFTER_CARRY_EN to add the out_carry result bit.
module pipelined_barrel_shifter
    import pipelined_barrel_shifter_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2
) (
    input logic                       clock,
    input logic                       reset,
    pipelined_barrel_shifter_if.slave bus
);

    localparam int SHAMT_W = shamt_width(WIDTH);
    localparam int NSTAGES = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    // Index 0 is the input side, index s+1 is the register of stage s.
    logic               valid_s [NSTAGES+1];
    logic               adv_s   [NSTAGES+1];
    logic [WIDTH-1:0]   data_s  [NSTAGES+1];
    logic [SHAMT_W-1:0] shamt_s [NSTAGES+1];
    logic [1:0]         mode_s  [NSTAGES+1];
    logic               sign_s  [NSTAGES+1];
    logic               unused_tail_s;

    assign valid_s[0]       = bus.in_valid;
    assign data_s[0]        = bus.in_data;
    assign shamt_s[0]       = bus.in_shamt;
    assign mode_s[0]        = bus.in_mode;
    assign sign_s[0]        = bus.in_data[WIDTH-1];
    assign adv_s[NSTAGES]   = bus.out_ready;
    assign bus.in_ready     = adv_s[0];
    assign bus.out_valid    = valid_s[NSTAGES];
    assign bus.out_data     = data_s[NSTAGES];
    assign unused_tail_s    = ^{shamt_s[NSTAGES], mode_s[NSTAGES], sign_s[NSTAGES]};

`ifdef SHIFTER_CARRY_EN
    logic               carry_s [NSTAGES+1];
    logic [SHAMT_W-1:0] carry_idx_s;

    // Index of the last bit shifted out; for ROR this is also the result MSB.
    always_comb begin
        carry_idx_s = {SHAMT_W{1'b0}};
        if (bus.in_mode == SHIFT_SLL) begin
            carry_idx_s = {SHAMT_W{1'b0}} - bus.in_shamt;
        end else begin
            carry_idx_s = bus.in_shamt - SHAMT_W'(1'b1);
        end
    end

    assign carry_s[0]    = (bus.in_shamt == {SHAMT_W{1'b0}}) ? 1'b0 : bus.in_data[carry_idx_s];
    assign bus.out_carry = carry_s[NSTAGES];
`endif

    for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
        localparam int FIRST = s * LEVELS_PER_STAGE;
        localparam int COUNT = (SHAMT_W - FIRST < LEVELS_PER_STAGE) ? (SHAMT_W - FIRST)
                                                                    : LEVELS_PER_STAGE;
        pipelined_barrel_shifter_shifter_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .FIRST   (FIRST),
            .COUNT   (COUNT)
        ) u_shifter_stage (
            .clock      (clock),
            .reset      (reset),
            .prev_valid (valid_s[s]),
            .prev_data  (data_s[s]),
            .prev_shamt (shamt_s[s]),
            .prev_mode  (mode_s[s]),
            .prev_sign  (sign_s[s]),
            .next_adv   (adv_s[s+1]),
            .valid_r    (valid_s[s+1]),
            .data_r     (data_s[s+1]),
            .shamt_r    (shamt_s[s+1]),
            .mode_r     (mode_s[s+1]),
            .sign_r     (sign_s[s+1]),
`ifdef SHIFTER_CARRY_EN
            .prev_carry (carry_s[s]),
            .carry_r    (carry_s[s+1]),
`endif
            .adv        (adv_s[s])
        );
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench: 32-bit/LPS=2 and 8-bit/LPS=1 instances.
module tb_pipelined_barrel_shifter;
    import pipelined_barrel_shifter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipelined_barrel_shifter_if #(.WIDTH(32)) bus ();
    pipelined_barrel_shifter_if #(.WIDTH(8))  bus8 ();

    pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(2)) dut (
        .clock (clock), .reset (reset), .bus (bus)
    );
    pipelined_barrel_shifter #(.WIDTH(8), .LEVELS_PER_STAGE(1)) dut8 (
        .clock (clock), .reset (reset), .bus (bus8)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
        logic        expc;
        string       name;
    } vec_t;

    vec_t vecs [17];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run32(input vec_t v);
        int cyc;
        bus.in_valid = 1'b1;
        bus.in_mode  = v.mode;
        bus.in_data  = v.data;
        bus.in_shamt = v.shamt;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEAD_BEEF;
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({v.name, " latency"}, 32'(cyc), 32'd3);
        check(v.name, bus.out_data, v.exp);
`ifdef SHIFTER_CARRY_EN
        check({v.name, " carry"}, {31'd0, bus.out_carry}, {31'd0, v.expc});
`endif
        step();
    endtask

    task automatic run8(input string name, input logic [1:0] mode, input logic [7:0] data,
                        input logic [2:0] shamt, input logic [7:0] exp, input logic expc);
        int cyc;
        bus8.in_valid = 1'b1;
        bus8.in_mode  = mode;
        bus8.in_data  = data;
        bus8.in_shamt = shamt;
        step();
        bus8.in_valid = 1'b0;
        cyc = 1;
        while (!bus8.out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'd3);
        check(name, {24'd0, bus8.out_data}, {24'd0, exp});
`ifdef SHIFTER_CARRY_EN
        check({name, " carry"}, {31'd0, bus8.out_carry}, {31'd0, expc});
`else
        if (expc === 1'bx) $display("unexpected carry vector");
`endif
        step();
    endtask

    initial begin
        int          first;
        int          last;
        int          acc;
        int          seen;
        logic [31:0] got [$];

        vecs[0]  = '{SHIFT_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, "sra_sign_31"};
        vecs[1]  = '{SHIFT_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, "srl_31"};
        vecs[2]  = '{SHIFT_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, "sll_31"};
        vecs[3]  = '{SHIFT_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, "ror_8"};
        vecs[4]  = '{SHIFT_SLL, 32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96, 1'b0, "sll_0"};
        vecs[5]  = '{SHIFT_SRL, 32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96, 1'b0, "srl_0"};
        vecs[6]  = '{SHIFT_SRA, 32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96, 1'b0, "sra_0"};
        vecs[7]  = '{SHIFT_ROR, 32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96, 1'b0, "ror_0"};
        vecs[8]  = '{SHIFT_SRA, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0, "sra_pos_4"};
        vecs[9]  = '{SHIFT_SRA, 32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0, "sra_neg_4"};
        vecs[10] = '{SHIFT_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, "ror_1"};
        vecs[11] = '{SHIFT_SLL, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 1'b1, "sll_16"};
        vecs[12] = '{SHIFT_SRL, 32'hF000_0000, 5'd5,  32'h0780_0000, 1'b0, "srl_5"};
        vecs[13] = '{SHIFT_ROR, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 1'b0, "ror_31"};
        vecs[14] = '{SHIFT_SLL, 32'hC000_0000, 5'd1,  32'h8000_0000, 1'b1, "sll_c0_1"};
        vecs[15] = '{SHIFT_SRL, 32'h0000_0002, 5'd1,  32'h0000_0001, 1'b0, "srl_2_1"};
        vecs[16] = '{SHIFT_SRL, 32'h0000_0003, 5'd1,  32'h0000_0001, 1'b1, "srl_3_1"};

        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = 32'd0;
        bus.in_shamt   = 5'd0;
        bus.in_mode    = SHIFT_SLL;
        bus.out_ready  = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in_data   = 8'd0;
        bus8.in_shamt  = 3'd0;
        bus8.in_mode   = SHIFT_SLL;
        bus8.out_ready = 1'b1;

        #12;
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset out_data", bus.out_data, 32'd0);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        step();

        for (int i = 0; i < 17; i++) run32(vecs[i]);

        run8("w8_sra_90_3", SHIFT_SRA, 8'h90, 3'd3, 8'hF2, 1'b0);
        run8("w8_ror_81_1", SHIFT_ROR, 8'h81, 3'd1, 8'hC0, 1'b1);
        run8("w8_sll_81_7", SHIFT_SLL, 8'h81, 3'd7, 8'h80, 1'b0);

        // Back-to-back stream of 1..8, SLL by 4, consumer always ready.
        first = -1;
        last  = -1;
        seen  = 0;
        got.delete();
        bus.in_mode  = SHIFT_SLL;
        bus.in_shamt = 5'd4;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd1;
        for (int c = 1; c <= 14; c++) begin
            if (bus.in_valid && !bus.in_ready) seen++;
            step();
            if (c < 8) bus.in_data = 32'(c + 1);
            else       bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                if (first < 0) first = c;
                last = c;
                got.push_back(bus.out_data);
            end
        end
        check("b2b in_ready stalls", 32'(seen), 32'd0);
        check("b2b first cycle", 32'(first), 32'd3);
        check("b2b last cycle", 32'(last), 32'd10);
        check("b2b count", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size(); i++) check("b2b data", got[i], 32'(i + 1) << 4);

        // Stall: consumer not ready for 5 cycles, producer keeps offering.
        bus.out_ready = 1'b0;
        bus.in_shamt  = 5'd1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h100;
        acc = 0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            if (bus.in_ready) acc++;
            step();
            bus.in_data = 32'h100 + 32'(acc);
            if (bus.out_valid) check("stall hold data", bus.out_data, 32'h200);
        end
        #1;
        check("stall accepts", 32'(acc), 32'd3);
        check("stall in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("stall out_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) got.push_back(bus.out_data);
            step();
        end
        check("drain count", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size(); i++) check("drain data", got[i], 32'h200 + 32'(2 * i));

        // Reset with three results in flight.
        bus.out_ready = 1'b0;
        bus.in_shamt  = 5'd0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h55;
        step();
        bus.in_data   = 32'h66;
        step();
        bus.in_data   = 32'h77;
        step();
        bus.in_valid  = 1'b0;
        check("flush pre out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("flush pre out_data", bus.out_data, 32'h55);
        #2;
        reset = 1'b1;
        #1;
        check("flush async out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush out_data", bus.out_data, 32'd0);
        check("flush in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) seen++;
            step();
        end
        check("flush no ghosts", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
